// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the streaming instruction-memory loader.
// No logic; the state enum and NOP constant are used by the top and the bench.
// The left_align helper zero-pads a partial word in its low bytes.
package instr_mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } loader_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Move the nbytes most recently shifted-in bytes to the top of the word.
    function automatic logic [31:0] left_align(input logic [31:0] w, input logic [2:0] nbytes);
        logic [31:0] r;
        case (nbytes)
            3'd1:    r = {w[7:0],  24'h0};
            3'd2:    r = {w[15:0], 16'h0};
            3'd3:    r = {w[23:0], 8'h0};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_word_assembler.sv
// Purpose: packs an MSB-first byte stream into 32-bit words, zero-padding a short final word.
// Latency: word and word_wr are combinational with the byte that completes the word.
// Backpressure: none; the caller presents only bytes it has already accepted.
module instr_word_assembler
    import instr_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    input  logic        byte_last,
    input  logic        flush,
    output logic [31:0] word_dat,
    output logic        word_wr
);

    logic [31:0] asm_q, asm_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] shifted;

    assign shifted = {asm_q[23:0], byte_dat};

    // Assembly register and byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q  <= '0;
            bcnt_q <= '0;
        end else begin
            asm_q  <= asm_d;
            bcnt_q <= bcnt_d;
        end
    end

    // Shift in bytes; emit a full word on the 4th byte, or a padded word on last/flush.
    always_comb begin
        asm_d    = asm_q;
        bcnt_d   = bcnt_q;
        word_wr  = 1'b0;
        word_dat = asm_q;
        if (clr) begin
            asm_d  = '0;
            bcnt_d = '0;
        end else if (byte_vld) begin
            asm_d  = shifted;
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
                word_wr  = 1'b1;
                word_dat = shifted;
            end else if (byte_last) begin
                word_wr  = 1'b1;
                word_dat = left_align(shifted, {1'b0, bcnt_q} + 3'd1);
            end
            if (byte_last) begin
                asm_d  = '0;
                bcnt_d = '0;
            end
        end else if (flush) begin
            // Checksum byte: write out whatever partial word is pending.
            word_wr  = (bcnt_q != 2'd0);
            word_dat = left_align(asm_q, {1'b0, bcnt_q});
            asm_d    = '0;
            bcnt_d   = '0;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Purpose: instruction memory for mips_core, loaded at run time from a byte stream; holds core until loaded.
// Latency: fetch is combinational; a loaded word is fetchable the cycle after its final byte edge.
// Backpressure: load_ready is high only in LOAD. Optional LOAD_CHECKSUM_EN: last byte is an XOR checksum.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic [7:0]             load_data,
    input  logic                   load_last,
    output logic                   load_ready,
    output logic                   load_done,
    output logic                   load_err,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   core_hold,
    output logic                   fetch_fault
);

    localparam logic [AW:0] WPTR_FULL = (AW+1)'(DEPTH);

    loader_state_t state_q, state_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic          load_ready_q, load_done_q, load_err_q, core_hold_q;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    logic        xfer, overflow, xfer_ok;
    logic        data_vld, data_last, flush, sum_ok;
    logic [31:0] word_dat;
    logic        word_wr;

    assign xfer     = load_valid && load_ready_q;
    assign overflow = xfer && (wptr_q == WPTR_FULL);
    // A load_start in the same cycle drops the byte.
    assign xfer_ok  = xfer && !load_start && !overflow;

`ifdef LOAD_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    assign data_vld  = xfer_ok && !load_last;
    assign data_last = 1'b0;
    assign flush     = xfer_ok && load_last;
    assign sum_ok    = (load_data == csum_q);

    // Running XOR of data bytes since load_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end

    // Clear on start, accumulate each accepted data byte.
    always_comb begin
        csum_d = csum_q;
        if (load_start)    csum_d = '0;
        else if (data_vld) csum_d = csum_q ^ load_data;
    end
`else
    assign data_vld  = xfer_ok;
    assign data_last = load_last;
    assign flush     = 1'b0;
    assign sum_ok    = 1'b1;
`endif

    instr_word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (load_start),
        .byte_vld  (data_vld),
        .byte_dat  (load_data),
        .byte_last (data_last),
        .flush     (flush),
        .word_dat  (word_dat),
        .word_wr   (word_wr)
    );

    // State, pointer and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            core_hold_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            load_ready_q <= (state_d == LOAD);
            load_done_q  <= (state_d == RUN);
            load_err_q   <= (state_d == ERR);
            core_hold_q  <= (state_d != RUN);
        end
    end

    // Next state: load_start always (re)starts a load; otherwise LOAD reacts to accepted bytes.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        if (load_start) begin
            state_d = LOAD;
            wptr_d  = '0;
        end else if (state_q == LOAD && xfer) begin
            if (overflow) begin
                state_d = ERR;
            end else begin
                if (word_wr)   wptr_d  = wptr_q + 1'b1;
                if (load_last) state_d = sum_ok ? RUN : ERR;
            end
        end
    end

    // Word array; deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (word_wr) mem[wptr_q[AW-1:0]] <= word_dat;
    end

    // Single-cycle fetch; NOP outside RUN or on a faulting pc.
    always_comb begin
        fetch_fault = 1'b0;
        instr       = NOP_INSTR[INSTR_WIDTH-1:0];
        if (state_q == RUN) begin
            fetch_fault = (pc[1:0] != 2'b00) || ((pc >> (AW + 2)) != '0);
            if (!fetch_fault) instr = mem[pc[AW+1:2]];
        end
    end

    assign load_ready = load_ready_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign core_hold  = core_hold_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a 256-word and a 4-word instance share all inputs.
// Stimulus pushes expectations into a queue; a negedge monitor pops and compares.
// Build with LOAD_CHECKSUM_EN defined to exercise the checksum variant instead.
module tb_instr_mem_loader;

    logic        clk;
    logic        rst;
    logic        load_start, load_valid, load_last;
    logic [7:0]  load_data;
    logic [31:0] pc;

    logic        b_ready, b_done, b_err, b_hold, b_fault;
    logic [31:0] b_instr;
    logic        s_ready, s_done, s_err, s_hold, s_fault;
    logic [31:0] s_instr;

    instr_mem_loader #(.DEPTH(256)) u_big (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(b_ready),
        .load_done(b_done), .load_err(b_err), .pc(pc), .instr(b_instr),
        .core_hold(b_hold), .fetch_fault(b_fault)
    );

    instr_mem_loader #(.DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(s_ready),
        .load_done(s_done), .load_err(s_err), .pc(pc), .instr(s_instr),
        .core_hold(s_hold), .fetch_fault(s_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind 0: {core_hold, load_ready, load_done, load_err, fetch_fault}; 1: instr; 2: mem word
    typedef struct {
        string       name;
        int          dut;
        int          kind;
        int          addr;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic push(input string n, input int d, input int k, input int a, input logic [31:0] v);
        exp_t e;
        e.name = n; e.dut = d; e.kind = k; e.addr = a; e.val = v;
        sb.push_back(e);
    endtask

    task automatic expect_obs(input string n, input int d, input logic [4:0] v);
        push(n, d, 0, 0, {27'h0, v});
    endtask

    task automatic expect_instr(input string n, input int d, input logic [31:0] v);
        push(n, d, 1, 0, v);
    endtask

    task automatic expect_mem(input string n, input int d, input int a, input logic [31:0] v);
        push(n, d, 2, a, v);
    endtask

    function automatic logic [31:0] actual(input exp_t e);
        logic [31:0] r;
        logic [7:0]  a;
        a = e.addr[7:0];
        r = '0;
        case (e.kind)
            0: r = (e.dut == 0) ? {27'h0, b_hold, b_ready, b_done, b_err, b_fault}
                                : {27'h0, s_hold, s_ready, s_done, s_err, s_fault};
            1: r = (e.dut == 0) ? b_instr : s_instr;
            default: r = (e.dut == 0) ? u_big.mem[a] : u_small.mem[a[1:0]];
        endcase
        return r;
    endfunction

    // Monitor: compare every pending expectation against the settled outputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = actual(e);
            vectors++;
            if (act !== e.val) begin
                miscompares++;
                $display("FAIL %s: actual=%h expected=%h", e.name, act, e.val);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img [8];
        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};

        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = 8'h00; pc = 32'h0;
        tick(); tick();
        vectors++;
        if ({b_hold, b_ready, b_done, b_err} !== 4'b1000 || b_instr !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_direct_big: hold=%b ready=%b done=%b err=%b instr=%h",
                     b_hold, b_ready, b_done, b_err, b_instr);
        end
        vectors++;
        if ({s_hold, s_ready, s_done, s_err} !== 4'b1000 || s_instr !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_direct_small: hold=%b ready=%b done=%b err=%b instr=%h",
                     s_hold, s_ready, s_done, s_err, s_instr);
        end
        expect_obs("rst_big", 0, 5'b10000);
        expect_obs("rst_small", 1, 5'b10000);
        expect_instr("rst_instr", 0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        expect_obs("idle_big", 0, 5'b10000);
        tick();

`ifdef LOAD_CHECKSUM_EN
        start_pulse();
        for (int i = 0; i < 4; i++) send(8'(i + 1), 1'b0);
        send(8'h04, 1'b1);
        expect_obs("csum_ok_run", 0, 5'b00100);
        expect_instr("csum_ok_word", 0, 32'h0102_0304);
        tick();

        start_pulse();
        for (int i = 0; i < 4; i++) send(8'(i + 1), 1'b0);
        send(8'h05, 1'b1);
        expect_obs("csum_bad_err", 0, 5'b10010);
        expect_instr("csum_bad_nop", 0, 32'h0);
        tick();

        start_pulse();
        expect_obs("csum_err_clear", 0, 5'b11000);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'h11, 1'b1);
        expect_obs("csum_partial_run", 0, 5'b00100);
        expect_instr("csum_partial_word", 0, 32'hAABB_0000);
        tick();
`else
        // Two-word image, last on the final byte.
        start_pulse();
        expect_obs("load_big", 0, 5'b11000);
        expect_instr("load_nop", 0, 32'h0);
        for (int i = 0; i < 8; i++) send(img[i], (i == 7));
        expect_obs("run_big", 0, 5'b00100);
        expect_instr("fetch0", 0, 32'h2008_0005);
        expect_mem("mem1_big", 0, 1, 32'h2009_0007);
        tick();
        pc = 32'h4;
        expect_instr("fetch4_big", 0, 32'h2009_0007);
        expect_instr("fetch4_small", 1, 32'h2009_0007);
        expect_obs("run_small", 1, 5'b00100);
        tick();
        pc = 32'h2;
        expect_obs("misalign", 0, 5'b00101);
        expect_instr("misalign_nop", 0, 32'h0);
        tick();
        pc = 32'h400;
        expect_obs("oor_big", 0, 5'b00101);
        expect_instr("oor_nop", 0, 32'h0);
        tick();
        pc = 32'h3FC;
        expect_obs("top_word_big", 0, 5'b00100);
        expect_obs("oor_small", 1, 5'b00101);
        tick();
        pc = 32'h0;

        // Reload from RUN with a partial word.
        start_pulse();
        expect_obs("hold_rise", 0, 5'b11000);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        expect_obs("partial_done", 0, 5'b00100);
        expect_instr("partial_word", 0, 32'hAABB_0000);
        tick();
        pc = 32'h4;
        expect_instr("retained_word", 0, 32'h2009_0007);
        tick();
        pc = 32'h0;

        // Reset after three bytes of a new load.
        start_pulse();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        rst = 1'b1;
        #1;
        expect_obs("rst_mid_load", 0, 5'b10000);
        expect_mem("rst_no_write", 0, 0, 32'hAABB_0000);
        tick();
        rst = 1'b0;
        tick();
        expect_obs("idle_after_rst", 0, 5'b10000);
        tick();

        // Overflow on the 4-word instance.
        start_pulse();
        for (int i = 0; i < 16; i++) send(8'(i + 1), 1'b0);
        expect_obs("full_small", 1, 5'b11000);
        send(8'h11, 1'b0);
        expect_obs("ovf_small", 1, 5'b10010);
        expect_obs("no_ovf_big", 0, 5'b11000);
        expect_mem("ovf_mem0", 1, 0, 32'h0102_0304);
        expect_mem("ovf_mem1", 1, 1, 32'h0506_0708);
        expect_mem("ovf_mem2", 1, 2, 32'h090A_0B0C);
        expect_mem("ovf_mem3", 1, 3, 32'h0D0E_0F10);
        tick();

        // load_start with a simultaneous byte: byte is dropped, err clears.
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'h77;
        tick();
        load_start = 1'b0; load_valid = 1'b0;
        expect_obs("err_clear_small", 1, 5'b11000);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'h77;
        tick();
        load_start = 1'b0; load_valid = 1'b0;
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        send(8'hEE, 1'b0);
        send(8'hFF, 1'b1);
        expect_obs("restart_run_big", 0, 5'b00100);
        expect_obs("restart_run_small", 1, 5'b00100);
        expect_instr("restart_word_big", 0, 32'hCCDD_EEFF);
        expect_instr("restart_word_small", 1, 32'hCCDD_EEFF);
        tick();
`endif

        tick();
        tick();
        if (vectors < 12) begin
            miscompares++;
            $display("FAIL too few vectors: %0d", vectors);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares != 0) $display("FAIL: %0d miscompares", miscompares);
        else                  $display("PASS");
        $finish;
    end

endmodule
